// File: rtl/spi_master_multi_if.sv
// Request/response bundle of the SPI master.
// The master modport belongs to the requester; the slave modport to the SPI block.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1
);
  logic [DATA_W-1:0] tx_data;
  logic [SEL_W-1:0]  tx_slave;
  logic [1:0]        tx_mode;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  modport master (
    output tx_data, tx_slave, tx_mode, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_slave, tx_mode, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_master_multi.sv
// SPI master: DATA_W-bit full-duplex frames, NUM_SLAVES chip selects,
// per-frame CPOL/CPHA, SCLK half-period of CLK_DIV clk cycles.
module spi_master_multi #(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int CLK_DIV    = 2,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_multi_if.slave     bus,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SLAVES-1:0] cs_n
);
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, PREP, XFER, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [EDGE_W-1:0] edges;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [SEL_W-1:0]  slave;
  logic              cpha;
  logic              half_done;
  logic              lead;
  logic              last_edge;

  assign half_done = (cnt == CNT_W'(CLK_DIV - 1));
  assign lead      = ~edges[0];
  assign last_edge = (edges == EDGE_W'(2 * DATA_W - 1));

  function automatic logic head(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(
    input logic [DATA_W-1:0] v
  );
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0}
                     : {1'b0, v[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(
    input logic [DATA_W-1:0] v,
    input logic              b
  );
    return MSB_FIRST ? {v[DATA_W-2:0], b}
                     : {b, v[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      edges        <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      slave        <= '0;
      cpha         <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      sclk         <= 1'b0;
      mosi         <= 1'b0;
      cs_n         <= '1;
    end else begin
      bus.rx_valid <= 1'b0;
      if (state != IDLE)
        cnt <= half_done ? '0 : cnt + CNT_W'(1);
      unique case (state)
        IDLE: if (bus.tx_valid) begin
          tx_sh        <= bus.tx_data;
          slave        <= bus.tx_slave;
          cpha         <= bus.tx_mode[0];
          sclk         <= bus.tx_mode[1];
          rx_sh        <= '0;
          cnt          <= '0;
          edges        <= '0;
          bus.tx_ready <= 1'b0;
          bus.busy     <= 1'b1;
          state        <= PREP;
        end
        PREP: if (half_done) begin
          // out-of-range index matches no select line
          for (int i = 0; i < NUM_SLAVES; i++)
            cs_n[i] <= (slave != SEL_W'(i));
          if (!cpha) begin
            mosi  <= head(tx_sh);
            tx_sh <= shift_out(tx_sh);
          end
          state <= XFER;
        end
        XFER: if (half_done) begin
          sclk  <= ~sclk;
          edges <= edges + EDGE_W'(1);
          if (lead ^ cpha) begin
            rx_sh <= shift_in(rx_sh, miso);
          end else if (!last_edge) begin
            mosi  <= head(tx_sh);
            tx_sh <= shift_out(tx_sh);
          end
          if (last_edge)
            state <= HOLD;
        end
        HOLD: if (half_done) begin
          cs_n         <= '1;
          mosi         <= 1'b0;
          bus.rx_data  <= rx_sh;
          bus.rx_valid <= 1'b1;
          bus.tx_ready <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
